rr_mux4: RTL and testbench

RR_MUX4 -- requirements
Module: rr_mux4

---
 rtl/rr_mux4.sv | 100 ++++++++++
 tb/tb_rr_mux4.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/rr_mux4.sv
// Purpose : round-robin merge of four valid/ready channels onto one tagged stream.
// Latency : 1 cycle from input transfer to word on out_data; one word per cycle sustained.
// Backpr. : in_ready is 0 while the output register is full and not draining, or when en=0.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   en                    - global enable for accepting new input words
//   in_valid / in_ready   - per-channel handshake (bit i = channel i)
//   in_data               - channel i at [i*WIDTH +: WIDTH]
//   out_valid / out_ready - output handshake
//   out_data / out_sel    - registered word and its source channel
module rr_mux4 #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;

  logic       slot_free;
  logic       gnt_vld;
  logic [1:0] gnt_idx;
  logic [1:0] cand;
  logic       in_xfer;

  // Output register can take a word if empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;

  // Search ptr, ptr+1, ptr+2, ptr+3 (mod 4). Iterating from the farthest
  // offset down lets the nearest valid channel overwrite earlier hits.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr_q + 2'(k);
      if (in_valid[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // rst_n gating keeps in_ready low for the whole reset window, not just after an edge.
  always_comb begin
    in_ready = 4'b0000;
    if (rst_n && en && slot_free && gnt_vld) begin
      in_ready[gnt_idx] = 1'b1;
    end
  end

  assign in_xfer = |in_ready;

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (in_xfer) begin
      // Reload covers the simultaneous drain case: no bubble, no loss.
      out_valid_d = 1'b1;
      out_data_d  = in_data[gnt_idx*WIDTH +: WIDTH];
      out_sel_d   = gnt_idx;
      ptr_d       = gnt_idx + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q       <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'd0;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux4.sv
// Purpose : randomized and directed bench for rr_mux4 against a behavioural model.
// Latency : model tracks the 1-cycle register stage explicitly.
// Backpr. : out_ready driven both directed and at random.
module tb_rr_mux4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  int         m_ptr;
  bit         m_valid;
  logic [W-1:0] m_data;
  int         m_sel;
  int         exp_g;
  bit         exp_fire;

  rr_mux4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan(input int i);
    return in_data[i*W +: W];
  endfunction

  // Inputs are already driven (at a negedge). Check, clock, advance model.
  task automatic step(input string tag);
    logic [3:0] exp_rdy;
    #1;
    exp_g = -1;
    for (int k = 0; k < 4; k++) begin
      if (exp_g < 0 && in_valid[(m_ptr + k) % 4]) exp_g = (m_ptr + k) % 4;
    end
    exp_fire = en && (!m_valid || out_ready) && (exp_g >= 0);
    exp_rdy  = exp_fire ? 4'(1 << exp_g) : 4'b0000;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
    chk({tag, "_out_valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      chk({tag, "_out_data"}, 32'(out_data), 32'(m_data));
      chk({tag, "_out_sel"}, 32'(out_sel), 32'(m_sel));
    end
    @(posedge clk);
    if (exp_fire) begin
      m_valid = 1'b1;
      m_data  = chan(exp_g);
      m_sel   = exp_g;
      m_ptr   = (exp_g + 1) % 4;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    chk({tag, "_valid_now"}, 32'(out_valid), 32'd0);
    chk({tag, "_data_now"}, 32'(out_data), 32'd0);
    chk({tag, "_sel_now"}, 32'(out_sel), 32'd0);
    chk({tag, "_rdy_now"}, 32'(in_ready), 32'd0);
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_rdy_hold"}, 32'(in_ready), 32'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; in_valid = 4'b0; in_data = '0; out_ready = 1'b0;
    m_valid = 1'b0; m_data = '0; m_sel = 0; m_ptr = 0;
    @(negedge clk);
    in_valid = 4'b1111;
    en = 1'b1;
    pulse_reset("por");

    // Single word on channel 0
    in_valid = 4'b0001; in_data = {8'h44, 8'h33, 8'h22, 8'h11}; out_ready = 1'b1;
    step("r031a");
    in_valid = 4'b0000;
    #1 chk("r031_data", 32'(out_data), 32'h11);
    chk("r031_sel", 32'(out_sel), 32'd0);
    chk("r031_vld", 32'(out_valid), 32'd1);
    step("r031b");

    // Rotation with all channels valid (ptr is 1 after previous grant)
    in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) step("r032");
    #1 chk("r032_sel_seq", 32'(out_sel), 32'd2);
    chk("r032_data_seq", 32'(out_data), 32'hA2);

    // Backpressure with a held word, then same-cycle drain+reload
    out_ready = 1'b0; in_valid = 4'b0010;
    for (int i = 0; i < 3; i++) step("r033_stall");
    out_ready = 1'b1;
    step("r033_reload");
    #1 chk("r033_sel", 32'(out_sel), 32'd1);
    chk("r033_vld", 32'(out_valid), 32'd1);
    in_valid = 4'b0000;
    step("r033_drain");

    // en=0 holds ptr; output still drains
    in_valid = 4'b1111; en = 1'b0;
    for (int i = 0; i < 5; i++) step("r034_off");
    en = 1'b1;
    step("r034_resume");
    #1 chk("r034_sel", 32'(out_sel), 32'd2);

    // Wrap: get ptr to 3, then 1001 -> 3 then 0
    in_valid = 4'b1001;
    step("r035a");
    step("r035b");
    #1 chk("r035_wrap", 32'(out_sel), 32'd0);

    // Reset with a word held
    in_valid = 4'b0100; out_ready = 1'b0;
    step("r036_load");
    pulse_reset("r036");
    in_valid = 4'b1111; out_ready = 1'b1;
    step("r036_first");
    #1 chk("r036_sel0", 32'(out_sel), 32'd0);

    // Random phase
    for (int i = 0; i < 400; i++) begin
      in_valid  = 4'($urandom_range(0, 15));
      in_data   = 32'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 7) != 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
